// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: captures an N-bit request vector and drains it one set bit per beat.
// Optional macro SEQ_PRIORITY_ENCODER_COUNT_EN adds out_count (popcount of the captured vector).
module seq_priority_encoder #(
  parameter int  N         = 8,
  parameter bit  LSB_FIRST = 1'b0,
  localparam int CW        = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_code,
  output logic          out_last,
  output logic          out_none
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
  , output logic [CW:0] out_count
`endif
);

  typedef enum logic [0:0] {IDLE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  pending, pending_nxt;
  logic [CW-1:0] sel;
  logic [N-1:0]  sel_oh;
  logic          single;

  // Later loop iterations override earlier ones, so scan order sets the priority.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (LSB_FIRST) begin
        if (pending[N-1-i]) sel = CW'(N-1-i);
      end else begin
        if (pending[i]) sel = CW'(i);
      end
    end
  end

  assign sel_oh = N'(1) << sel;
  assign single = ((pending & (pending - 1'b1)) == '0);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (in_valid) begin
          pending_nxt = in_data;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          pending_nxt = pending & ~sel_oh;
          if (single) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DRAIN);
  assign out_code  = out_valid ? sel : '0;
  assign out_last  = out_valid && single;
  assign out_none  = out_valid && (pending == '0);

`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
  logic [CW:0] in_pop;

  always_comb begin
    in_pop = '0;
    for (int i = 0; i < N; i++) in_pop = in_pop + (CW+1)'(in_data[i]);
  end

  // Count reflects the vector as captured, not what is still pending.
  always_ff @(posedge clk) begin
    if (rst)                         out_count <= '0;
    else if (state == IDLE && in_valid) out_count <= in_pop;
  end
`endif

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder: one MSB-first and one LSB-first instance share stimulus.
module tb_seq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready0, out_valid0, out_last0, out_none0;
  logic [2:0] out_code0;
  logic       in_ready1, out_valid1, out_last1, out_none1;
  logic [2:0] out_code1;
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
  logic [3:0] out_count0, out_count1;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_priority_encoder #(.N(8), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_code(out_code0),
    .out_last(out_last0), .out_none(out_none0)
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
    , .out_count(out_count0)
`endif
  );

  seq_priority_encoder #(.N(8), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_code(out_code1),
    .out_last(out_last1), .out_none(out_none1)
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
    , .out_count(out_count1)
`endif
  );

  // Presents v for exactly one accept edge; returns just after that edge.
  task automatic send(input logic [7:0] v);
    @(posedge clk); #1 in_valid = 1'b1; in_data = v;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
    checks++; if (in_ready0 !== 1'b0) begin errs++; $display("FAIL reset_in_ready got=%b exp=0", in_ready0); end
    checks++; if (out_code0 !== 3'd0) begin errs++; $display("FAIL reset_out_code got=%0d exp=0", out_code0); end
    checks++; if (out_last0 !== 1'b0) begin errs++; $display("FAIL reset_out_last got=%b exp=0", out_last0); end
    checks++; if (out_none0 !== 1'b0) begin errs++; $display("FAIL reset_out_none got=%b exp=0", out_none0); end
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
    checks++; if (out_count0 !== 4'd0) begin errs++; $display("FAIL reset_out_count got=%0d exp=0", out_count0); end
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready0); end
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid0); end
  endtask

  task automatic test_basic;
    logic [2:0] exp [3];
    exp = '{3'd7, 3'd5, 3'd2};
    out_ready = 1'b1;
    send(8'b1010_0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid0 !== 1'b1) begin errs++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, out_valid0); end
      checks++; if (out_code0 !== exp[i]) begin errs++; $display("FAIL basic_code[%0d] got=%0d exp=%0d", i, out_code0, exp[i]); end
      checks++; if (out_last0 !== (i == 2)) begin errs++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, out_last0, (i == 2)); end
      checks++; if (out_none0 !== 1'b0) begin errs++; $display("FAIL basic_none[%0d] got=%b exp=0", i, out_none0); end
      checks++; if (in_ready0 !== 1'b0) begin errs++; $display("FAIL basic_in_ready[%0d] got=%b exp=0", i, in_ready0); end
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
      checks++; if (out_count0 !== 4'd3) begin errs++; $display("FAIL basic_count[%0d] got=%0d exp=3", i, out_count0); end
`endif
    end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL basic_end_valid got=%b exp=0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL basic_end_in_ready got=%b exp=1", in_ready0); end
  endtask

  task automatic test_zero;
    out_ready = 1'b1;
    send(8'h00);
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b1) begin errs++; $display("FAIL zero_valid got=%b exp=1", out_valid0); end
    checks++; if (out_none0 !== 1'b1) begin errs++; $display("FAIL zero_none got=%b exp=1", out_none0); end
    checks++; if (out_code0 !== 3'd0) begin errs++; $display("FAIL zero_code got=%0d exp=0", out_code0); end
    checks++; if (out_last0 !== 1'b1) begin errs++; $display("FAIL zero_last got=%b exp=1", out_last0); end
    checks++; if (out_none1 !== 1'b1) begin errs++; $display("FAIL zero_none_lsb got=%b exp=1", out_none1); end
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
    checks++; if (out_count0 !== 4'd0) begin errs++; $display("FAIL zero_count got=%0d exp=0", out_count0); end
`endif
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL zero_end_valid got=%b exp=0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL zero_end_in_ready got=%b exp=1", in_ready0); end
  endtask

  // out_ready follows 1,0,0,1,... ; expected code only advances on a transfer.
  task automatic test_backpressure;
    int n;
    n = 0;
    send(8'hFF);
    for (int c = 0; c < 40; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      @(negedge clk);
      checks++; if (out_valid0 !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, out_valid0); end
      checks++; if (out_code0 !== 3'(7 - n)) begin errs++; $display("FAIL bp_code[%0d] got=%0d exp=%0d", c, out_code0, 7 - n); end
      checks++; if (out_last0 !== (n == 7)) begin errs++; $display("FAIL bp_last[%0d] got=%b exp=%b", c, out_last0, (n == 7)); end
      checks++; if (out_code1 !== 3'(n)) begin errs++; $display("FAIL bp_code_lsb[%0d] got=%0d exp=%0d", c, out_code1, n); end
      if (out_ready) n++;
      if (n == 8) break;
      @(posedge clk); #1;
    end
    checks++; if (n !== 8) begin errs++; $display("FAIL bp_transfers got=%0d exp=8", n); end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL bp_end_valid got=%b exp=0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL bp_end_in_ready got=%b exp=1", in_ready0); end
  endtask

  task automatic test_lsb_first;
    out_ready = 1'b1;
    send(8'b1000_0001);
    @(negedge clk);
    checks++; if (out_code1 !== 3'd0) begin errs++; $display("FAIL lsb_code0 got=%0d exp=0", out_code1); end
    checks++; if (out_last1 !== 1'b0) begin errs++; $display("FAIL lsb_last0 got=%b exp=0", out_last1); end
    checks++; if (out_code0 !== 3'd7) begin errs++; $display("FAIL msb_code0 got=%0d exp=7", out_code0); end
    @(negedge clk);
    checks++; if (out_code1 !== 3'd7) begin errs++; $display("FAIL lsb_code1 got=%0d exp=7", out_code1); end
    checks++; if (out_last1 !== 1'b1) begin errs++; $display("FAIL lsb_last1 got=%b exp=1", out_last1); end
    checks++; if (out_code0 !== 3'd0) begin errs++; $display("FAIL msb_code1 got=%0d exp=0", out_code0); end
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0) begin errs++; $display("FAIL lsb_end_valid got=%b exp=0", out_valid1); end
    send(8'b0001_0000);
    @(negedge clk);
    checks++; if (out_code1 !== 3'd4) begin errs++; $display("FAIL lsb_single_code got=%0d exp=4", out_code1); end
    checks++; if (out_last1 !== 1'b1) begin errs++; $display("FAIL lsb_single_last got=%b exp=1", out_last1); end
    checks++; if (out_none1 !== 1'b0) begin errs++; $display("FAIL lsb_single_none got=%b exp=0", out_none1); end
    checks++; if (out_code0 !== 3'd4) begin errs++; $display("FAIL msb_single_code got=%0d exp=4", out_code0); end
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0) begin errs++; $display("FAIL lsb_single_end got=%b exp=0", out_valid1); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    send(8'hF0);
    @(negedge clk);
    checks++; if (out_code0 !== 3'd7) begin errs++; $display("FAIL rmid_first_code got=%0d exp=7", out_code0); end
    checks++; if (out_code1 !== 3'd4) begin errs++; $display("FAIL rmid_first_code_lsb got=%0d exp=4", out_code1); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready0 !== 1'b0) begin errs++; $display("FAIL rmid_in_ready_in_rst got=%b exp=0", in_ready0); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL rmid_valid got=%b exp=0", out_valid0); end
    checks++; if (out_valid1 !== 1'b0) begin errs++; $display("FAIL rmid_valid_lsb got=%b exp=0", out_valid1); end
    checks++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready0); end
    send(8'h02);
    @(negedge clk);
    checks++; if (out_code0 !== 3'd1) begin errs++; $display("FAIL rmid_next_code got=%0d exp=1", out_code0); end
    checks++; if (out_last0 !== 1'b1) begin errs++; $display("FAIL rmid_next_last got=%b exp=1", out_last0); end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL rmid_next_end got=%b exp=0", out_valid0); end
  endtask

  task automatic test_no_capture;
    out_ready = 1'b0;
    send(8'h05);
    in_valid = 1'b1; in_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_code0 !== 3'd2) begin errs++; $display("FAIL nocap_code[%0d] got=%0d exp=2", i, out_code0); end
      checks++; if (out_last0 !== 1'b0) begin errs++; $display("FAIL nocap_last[%0d] got=%b exp=0", i, out_last0); end
      checks++; if (out_code1 !== 3'd0) begin errs++; $display("FAIL nocap_code_lsb[%0d] got=%0d exp=0", i, out_code1); end
      checks++; if (in_ready0 !== 1'b0) begin errs++; $display("FAIL nocap_in_ready[%0d] got=%b exp=0", i, in_ready0); end
`ifdef SEQ_PRIORITY_ENCODER_COUNT_EN
      checks++; if (out_count0 !== 4'd2) begin errs++; $display("FAIL nocap_count[%0d] got=%0d exp=2", i, out_count0); end
`endif
      @(posedge clk); #1 in_data = in_data + 8'h11;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_code0 !== 3'd2) begin errs++; $display("FAIL nocap_beat0 got=%0d exp=2", out_code0); end
    @(negedge clk);
    checks++; if (out_code0 !== 3'd0) begin errs++; $display("FAIL nocap_beat1 got=%0d exp=0", out_code0); end
    checks++; if (out_last0 !== 1'b1) begin errs++; $display("FAIL nocap_beat1_last got=%b exp=1", out_last0); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL nocap_end_valid got=%b exp=0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL nocap_end_in_ready got=%b exp=1", in_ready0); end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0) begin errs++; $display("FAIL nocap_idle_valid got=%b exp=0", out_valid0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_lsb_first();
    test_reset_mid();
    test_no_capture();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
- Sequential 8-to-3 priority encoder. It is the inverse of the 3-to-8 minterm decoder used in the combinational adder labs.
- Accepts an N-bit request vector over a valid/ready handshake, then drains it one set bit per output beat, highest priority first, emitting the binary index of each set bit.
- Used as the encoding end of decoder-based datapaths and as a simple request scanner for the lab's arbiter exercises.

Parameters:
- N, 8, width of the input vector; must be a power of 2, ≥ 2.
- CW, $clog2(N), width of the output code; derived, not overridden.
- LSB_FIRST, 0, 0 = highest index has priority; 1 = index 0 has priority.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request vector is present.
- in_ready  out  1  block can accept a vector.
- in_data  in  N  request vector; bit i set = request i.
- out_valid  out  1  out_code/out_last/out_none are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_code  out  CW  binary index of the current highest-priority pending bit.
- out_last  out  1  current beat is the final beat for this vector.
- out_none  out  1  captured vector was all zeros; out_code = 0 on this beat.

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- State machine: IDLE, DRAIN.
- Internal state: pending register (N bits), state register.
- Reset values:
  - state = IDLE, pending = 0.
  - out_valid = 0, out_code = 0, out_last = 0, out_none = 0.
  - in_ready = 0 while rst is high; in_ready = 1 on the first cycle after rst falls.
- in_ready = (state == IDLE) && !rst. No new vector is accepted while draining; no overlap of vectors.
- Capture: when in IDLE and in_valid && in_ready at a clock edge:
  - pending <= in_data, state <= DRAIN.
  - out_valid = 1 from the next cycle. Latency from accept to first beat is exactly 1 cycle.
- Outputs in DRAIN are registered/derived from pending only, never from in_data:
  - out_code = index of the priority-selected set bit of pending.
  - out_last = 1 when pending has at most one bit set.
  - out_none = 1 when pending == 0; in that case out_code = 0 and out_last = 1.
- Beat transfer: on out_valid && out_ready, the selected bit is cleared in pending.
  - If out_last, state <= IDLE, and out_valid = 0 on the next cycle.
  - in_ready = 1 on the next cycle. Minimum gap between vectors is 1 idle cycle.
- Backpressure: while out_valid && !out_ready, out_code, out_last, out_none and pending hold stable. in_data changes are ignored.
- Zero vector: exactly one beat is emitted, with out_none = 1, out_last = 1, out_code = 0.
- Single-bit vector: one beat, out_last = 1, out_none = 0.
- All-ones vector: N beats.
  - LSB_FIRST = 0: codes N-1 down to 0.
  - LSB_FIRST = 1: codes 0 up to N-1.
- Throughput: one beat per cycle with out_ready held high. Vector with k set bits occupies k DRAIN cycles (1 if k = 0) plus 1 IDLE cycle.
- Reset mid-drain: on the edge where rst = 1, pending is cleared and state returns to IDLE. out_valid drops the following cycle and no further beats are emitted. A partially drained vector is discarded.
- in_valid while not ready: no effect. The producer must hold in_data until accepted.

Optional Feature:
- Macro: SEQ_PRIORITY_ENCODER_COUNT_EN.
- Defined:
  - Adds output port out_count (CW+1 bits) = number of set bits in the vector captured at accept. Updated at capture and held through the whole DRAIN.
  - Reset value 0. Equals 0 for a zero vector.
- Undefined: the port and its popcount logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then accept in_data = 8'b1010_0100, out_ready = 1, LSB_FIRST = 0 -> beats out_code = 7, 5, 2 on consecutive cycles; out_last only on code 2; in_ready returns the cycle after; out_count = 3 if COUNT_EN.
- Accept 8'h00 -> single beat with out_none = 1, out_code = 0, out_last = 1; then IDLE.
- Accept 8'hFF with out_ready toggling 1,0,0,1,... -> codes 7..0 in order; values held stable on every stalled cycle; exactly 8 transfers.
- LSB_FIRST = 1, accept 8'b1000_0001 -> codes 0 then 7 (last); accept 8'b0001_0000 -> single beat code 4, out_last = 1.
- Accept 8'hF0, transfer one beat (code 7), assert rst for 1 cycle -> out_valid = 0 after reset; in_ready = 1 next cycle; next vector 8'h02 yields only code 1.
- Hold in_valid = 1 with changing in_data during a drain -> none of the new values are captured; only the vector present at the IDLE accept edge is encoded.
